// File: rtl/lms_rx_deinterleave.sv
// lms_rx_deinterleave: framed I/Q deinterleaver for the LMS RX bus feeding the umtrx_core ADC inputs.
// Pairs an I sample (rx_iqsel=1) with the following Q sample (rx_iqsel=0) and emits one aligned
// pair per adc_strobe. Framing faults (duplicate I, orphan Q while locked) are counted and drop lock.
// Optional macro LMS_RX_PATTERN_CHECK_EN adds a ramp/complement pattern checker
// (pat_clear in, pat_err_cnt out).
module lms_rx_deinterleave #(
    parameter int DW         = 12,
    parameter int LOCK_PAIRS = 16,
    parameter int ERRW       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            swap_iq,
    input  logic            rx_iqsel,
    input  logic [DW-1:0]   rx_d,
    output logic [DW-1:0]   adc_a,
    output logic [DW-1:0]   adc_b,
    output logic            adc_strobe,
    output logic            locked,
    output logic [ERRW-1:0] err_cnt,
    input  logic            err_clear
`ifdef LMS_RX_PATTERN_CHECK_EN
    ,
    input  logic            pat_clear,
    output logic [15:0]     pat_err_cnt
`endif
);

    typedef enum logic {WAIT_I, HAVE_I} state_t;

    state_t        state;
    logic [DW-1:0] i_hold;
    logic [DW-1:0] pair_i;
    logic [DW-1:0] pair_q;
    logic          pend;
    logic [7:0]    good_cnt;
    logic [7:0]    good_inc;
    logic [7:0]    good_next;
    logic          dup_i;
    logic          orphan_q;
    logic          pair_in;
    logic          frame_err;
    logic          emit;

    // A Q completing a held I forms a pair; orphan Q only counts as a fault once locked.
    assign dup_i     = enable && state == HAVE_I && rx_iqsel;
    assign orphan_q  = enable && state == WAIT_I && !rx_iqsel && locked;
    assign pair_in   = enable && state == HAVE_I && !rx_iqsel;
    assign frame_err = dup_i || orphan_q;
    // Pair captured on the previous edge is presented now unless enable has fallen.
    assign emit      = enable && pend;

    // Good-pair count advances with each presented pair and saturates at the lock threshold.
    always_comb begin
        good_inc  = (emit && good_cnt < 8'(LOCK_PAIRS)) ? good_cnt + 8'd1 : good_cnt;
        good_next = (!enable || frame_err) ? 8'd0 : good_inc;
    end

    // Framing FSM: any I (re)loads the hold register, any Q returns to hunting for I.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= WAIT_I;
            i_hold <= '0;
        end else if (!enable) begin
            state  <= WAIT_I;
        end else if (rx_iqsel) begin
            state  <= HAVE_I;
            i_hold <= rx_d;
        end else begin
            state  <= WAIT_I;
        end
    end

    // Capture the completed pair so the I hold register is free for the next I.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= 1'b0;
            pair_i <= '0;
            pair_q <= '0;
        end else begin
            pend <= pair_in;
            if (pair_in) begin
                pair_i <= i_hold;
                pair_q <= rx_d;
            end
        end
    end

    // Output registers: load with optional rail swap and pulse the strobe for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_a      <= '0;
            adc_b      <= '0;
            adc_strobe <= 1'b0;
        end else begin
            adc_strobe <= emit;
            if (emit) begin
                adc_a <= swap_iq ? pair_q : pair_i;
                adc_b <= swap_iq ? pair_i : pair_q;
            end
        end
    end

    // Lock tracks the saturated good-pair count; faults and disable clear both together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            good_cnt <= good_next;
            locked   <= good_next == 8'(LOCK_PAIRS);
        end
    end

    // Saturating framing-error counter; clear wins over a simultaneous fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clear) begin
            err_cnt <= '0;
        end else if (frame_err && !(&err_cnt)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

`ifdef LMS_RX_PATTERN_CHECK_EN
    logic          seeded;
    logic [DW-1:0] ref_i;
    logic          pat_bad;

    assign pat_bad = seeded && ((pair_i != ref_i + DW'(1)) || (pair_q != ~pair_i));

    // Pattern checker: the first pair after reset, fault or disable only seeds the reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seeded      <= 1'b0;
            ref_i       <= '0;
            pat_err_cnt <= '0;
        end else begin
            seeded <= (!enable || frame_err) ? 1'b0 : (seeded || emit);
            if (emit)
                ref_i <= pair_i;
            if (pat_clear)
                pat_err_cnt <= '0;
            else if (emit && pat_bad && !(&pat_err_cnt))
                pat_err_cnt <= pat_err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lms_rx_deinterleave.sv
// tb_lms_rx_deinterleave: directed and randomized checks of lms_rx_deinterleave against a pair-level reference model.
module tb_lms_rx_deinterleave;

    localparam int DW   = 12;
    localparam int LOCK = 16;
    localparam int ERRW = 16;
    localparam int EMAX = (1 << ERRW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic            swap_iq = 1'b0;
    logic            rx_iqsel = 1'b0;
    logic [DW-1:0]   rx_d = '0;
    logic            err_clear = 1'b0;
    logic [DW-1:0]   adc_a;
    logic [DW-1:0]   adc_b;
    logic            adc_strobe;
    logic            locked;
    logic [ERRW-1:0] err_cnt;
`ifdef LMS_RX_PATTERN_CHECK_EN
    logic            pat_clear = 1'b0;
    logic [15:0]     pat_err_cnt;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model: an optional held I, a queue of completed pairs awaiting presentation,
    // a good-pair tally and an error tally.
    bit              m_have;
    logic [DW-1:0]   m_hi;
    logic [2*DW-1:0] m_pairs[$];
    int              m_good;
    bit              m_lk;
    int              m_err;
    bit              m_stb;
    logic [DW-1:0]   m_a;
    logic [DW-1:0]   m_b;

    always #5 clk = ~clk;

    lms_rx_deinterleave #(.DW(DW), .LOCK_PAIRS(LOCK), .ERRW(ERRW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .swap_iq    (swap_iq),
        .rx_iqsel   (rx_iqsel),
        .rx_d       (rx_d),
        .adc_a      (adc_a),
        .adc_b      (adc_b),
        .adc_strobe (adc_strobe),
        .locked     (locked),
        .err_cnt    (err_cnt),
        .err_clear  (err_clear)
`ifdef LMS_RX_PATTERN_CHECK_EN
        ,
        .pat_clear  (pat_clear),
        .pat_err_cnt(pat_err_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("strobe", {31'd0, adc_strobe}, {31'd0, m_stb});
        chk("adc_a", {20'd0, adc_a}, {20'd0, m_a});
        chk("adc_b", {20'd0, adc_b}, {20'd0, m_b});
        chk("locked", {31'd0, locked}, {31'd0, m_lk});
        chk("err_cnt", {16'd0, err_cnt}, m_err);
    endtask

    task automatic model_reset();
        m_have = 0; m_hi = '0; m_pairs.delete(); m_good = 0; m_lk = 0;
        m_err = 0; m_stb = 0; m_a = '0; m_b = '0;
    endtask

    // One clock edge of the spec behaviour, using the inputs present at that edge.
    task automatic model_edge();
        bit ferr;
        bit was_locked;
        logic [2*DW-1:0] p;
        ferr = 0;
        was_locked = m_lk;
        m_stb = 0;
        if (!enable) begin
            m_have = 0; m_pairs.delete(); m_good = 0; m_lk = 0;
        end else begin
            if (m_pairs.size() > 0) begin
                p = m_pairs.pop_front();
                m_stb = 1;
                m_a = swap_iq ? p[DW-1:0] : p[2*DW-1:DW];
                m_b = swap_iq ? p[2*DW-1:DW] : p[DW-1:0];
                m_good = (m_good < LOCK) ? m_good + 1 : LOCK;
                m_lk = (m_good == LOCK);
            end
            if (rx_iqsel) begin
                ferr = m_have;
                m_have = 1;
                m_hi = rx_d;
            end else if (m_have) begin
                m_pairs.push_back({m_hi, rx_d});
                m_have = 0;
            end else begin
                ferr = was_locked;
            end
            if (ferr) begin
                m_good = 0; m_lk = 0;
            end
        end
        if (err_clear) m_err = 0;
        else if (ferr && m_err < EMAX) m_err++;
    endtask

    task automatic step(input logic iq, input logic [DW-1:0] d);
        rx_iqsel = iq;
        rx_d = d;
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    task automatic pairs(input int n, input logic [DW-1:0] i_v, input logic [DW-1:0] q_v);
        for (int k = 0; k < n; k++) begin
            step(1'b1, i_v);
            step(1'b0, q_v);
        end
    endtask

    initial begin
        logic prev_iq;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;

        // Clean stream: lock after the 16th strobe, no errors.
        pairs(20, 12'h123, 12'h456);
        chk("clean_locked", {31'd0, locked}, 32'd1);
        chk("clean_a", {20'd0, adc_a}, 32'h123);
        chk("clean_b", {20'd0, adc_b}, 32'h456);

        // Swapped rails.
        swap_iq = 1'b1;
        pairs(4, 12'h123, 12'h456);
        chk("swap_a", {20'd0, adc_a}, 32'h456);
        chk("swap_b", {20'd0, adc_b}, 32'h123);
        swap_iq = 1'b0;

        // Faults after lock: duplicate I, later orphan Q, then re-lock.
        step(1'b1, 12'hAAA);
        step(1'b1, 12'hBBB);
        step(1'b0, 12'hCCC);
        step(1'b0, 12'h000);
        chk("dup_pair_a", {20'd0, adc_a}, 32'hBBB);
        pairs(17, 12'h123, 12'h456);
        step(1'b0, 12'h777);
        step(1'b0, 12'h777);
        chk("fault_err", {16'd0, err_cnt}, 32'd2);
        pairs(17, 12'h321, 12'h654);
        chk("relock", {31'd0, locked}, 32'd1);

        // Reset asserted between I and Q: outputs clear immediately.
        step(1'b1, 12'h5A5);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 12'h0F0);
        step(1'b1, 12'h111);
        step(1'b0, 12'h222);
        step(1'b1, 12'h333);
        chk("post_rst_a", {20'd0, adc_a}, 32'h111);

        // Enable dropped in the Q cycle: pair is dropped.
        step(1'b0, 12'h444);
        step(1'b1, 12'h555);
        enable = 1'b0;
        step(1'b0, 12'h666);
        enable = 1'b1;
        step(1'b1, 12'h777);
        chk("en_drop_stb", {31'd0, adc_strobe}, 32'd0);
        step(1'b0, 12'h888);
        step(1'b1, 12'h999);
        chk("en_resume_b", {20'd0, adc_b}, 32'h888);

        // Randomized stream with framing glitches, enable gaps, swaps and clears.
        prev_iq = 1'b0;
        for (int k = 0; k < 600; k++) begin
            enable = ($urandom_range(0, 24) != 0);
            err_clear = ($urandom_range(0, 39) == 0);
            if (k % 60 == 0) swap_iq = $urandom_range(0, 1);
            prev_iq = ($urandom_range(0, 11) == 0) ? prev_iq : ~prev_iq;
            step(prev_iq, DW'($urandom));
        end
        enable = 1'b1;
        err_clear = 1'b0;
        swap_iq = 1'b0;

        // Saturation: continuous duplicate I, then clear together with an error.
        err_clear = 1'b1;
        step(1'b1, 12'h001);
        err_clear = 1'b0;
        for (int k = 0; k < EMAX + 4; k++) step(1'b1, 12'h002);
        chk("sat_err", {16'd0, err_cnt}, 32'hFFFF);
        err_clear = 1'b1;
        step(1'b1, 12'h003);
        err_clear = 1'b0;
        chk("clr_prio", {16'd0, err_cnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lms_rx_deinterleave.md
Name: lms_rx_deinterleave

Overview:
- Sits between the IOB-registered LMS RX bus (12-bit data plus IQSEL, interleaved I/Q at lms_clk) and the umtrx_core ADC inputs (adc_a, adc_b, adc_strobe).
- Replaces the bare IQSEL mux with a framed deinterleaver. It pairs I then Q, emits one aligned pair per strobe, and detects IQSEL framing faults.
- Reports lock status and a saturating framing-error count for the control-register readback.

Parameters:
- DW, 12, sample width per rail.
- LOCK_PAIRS, 16, consecutive good pairs required before lock asserts (range 1..255).
- ERRW, 16, error counter width.

Ports:
- clk  in  1  lms_clk domain clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = run; 0 = hold idle (no strobes, FSM forced to WAIT_I).
- swap_iq  in  1  1 = exchange the a/b outputs (static control).
- rx_iqsel  in  1  registered IQSEL from the pad (1 = I sample, 0 = Q sample).
- rx_d  in  DW  registered sample from the pad.
- adc_a  out  DW  I sample of the pair (Q when swap_iq=1).
- adc_b  out  DW  Q sample of the pair (I when swap_iq=1).
- adc_strobe  out  1  one-cycle pulse; adc_a/adc_b are valid and held until the next strobe.
- locked  out  1  framing lock indicator.
- err_cnt  out  ERRW  saturating count of framing errors.
- err_clear  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset values: adc_a=0, adc_b=0, adc_strobe=0, locked=0, err_cnt=0, FSM=WAIT_I, good-pair count=0, i_hold=0.
- FSM states: WAIT_I, HAVE_I.
  - WAIT_I and iqsel=1: i_hold<=rx_d; go to HAVE_I.
  - WAIT_I and iqsel=0: orphan Q. Framing error if locked=1; if unlocked, silently discarded (initial hunt). Stay in WAIT_I.
  - HAVE_I and iqsel=0: emit the pair; go to WAIT_I.
  - HAVE_I and iqsel=1: duplicate I. Framing error; i_hold is overwritten with the new sample; stay in HAVE_I.
- Emit timing: the Q sample enters on edge n. On edge n+1, adc_a/adc_b are updated and adc_strobe=1 for exactly that cycle. Latency from Q-in to strobe is 1 cycle; from I-in it is 2 cycles.
- Swap: applied at output-register load. swap_iq=0: adc_a=I, adc_b=Q. swap_iq=1: reversed.
- Outputs hold their last values while adc_strobe=0. Strobes are at most every 2nd cycle.
- Lock:
  - Each emitted pair increments the good-pair count, saturating at LOCK_PAIRS.
  - locked is set on the cycle the count reaches LOCK_PAIRS.
  - Any framing error clears both the count and locked on the same edge.
- err_cnt:
  - +1 per framing error, saturating at all-ones (no wrap).
  - err_clear has priority: clear and error in the same cycle gives err_cnt=0.
- enable=0:
  - FSM goes to WAIT_I, the partial I is discarded, no strobe is generated, and the good-pair count clears to 0.
  - locked drops on the next edge; err_cnt is held.
  - A pair whose Q arrives in the cycle enable falls is dropped.
- rst_n asserted mid-pair: everything returns to reset values immediately (asynchronously); no strobe is produced on release until a full I,Q sequence arrives.

Optional Feature:
- Macro: LMS_RX_PATTERN_CHECK_EN.
- When defined, adds output pat_err_cnt [15:0] (saturating) and input pat_clear. On each emitted pair (pre-swap), the checker expects:
  - I = previous I + 1 mod 2^DW;
  - Q = bitwise ~I.
- A mismatch increments pat_err_cnt by 1. The first pair after reset, lock loss, or enable rise only seeds the reference and is never counted.
- When undefined, these ports and all related logic are absent; the rest of the behaviour is identical.

Test Plan:
- Clean stream: rx_iqsel alternating 1,0 with I=0x123, Q=0x456, enable=1 → adc_strobe pulses every 2 cycles, 1 cycle after each Q; adc_a=0x123, adc_b=0x456; locked rises on the 16th strobe; err_cnt=0.
- Swap: same stream with swap_iq=1 → adc_a=0x456, adc_b=0x123.
- Faults after lock: inject IQSEL 1,1 (duplicate I) then later 0,0 (orphan Q) → err_cnt=2; locked drops on the first fault. After the duplicate, the pair uses the second I value. Lock re-asserts after 16 further good pairs.
- Saturation/clear: force more than 65535 errors → err_cnt=0xFFFF. Assert err_clear together with an error → err_cnt=0.
- Mid-pair disruptions:
  - rst_n asserted between I and Q → outputs are 0 immediately; the first strobe after release follows a fresh I,Q.
  - enable dropped in the Q cycle → no strobe.
- (With LMS_RX_PATTERN_CHECK_EN) Ramp I=0..4095 wrapping, Q=~I → pat_err_cnt=0 across the 0xFFF→0x000 wrap. Corrupting one Q → pat_err_cnt=1.
